// File: rtl/dmux_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_router_pkg
//  Purpose  : Shared types, constants and elaboration helpers for the
//             dmux_router stream demultiplexer and its per-channel slots.
//  Contents : beat_t        - reference beat layout (payload plus select)
//                             at the default 16-bit / 2-bit geometry
//             slot_state_t  - EMPTY/FULL state of a one-entry output slot
//             sel_fits()    - true when N_OUT channels fit in SEL_W bits
//             cnt_sat()     - saturation value of an n-bit drop counter
//  Revision : 1.0  initial release
// ============================================================================
package dmux_router_pkg;

    localparam int BEAT_DATA_W = 16;
    localparam int BEAT_SEL_W  = 2;

    // Beat as presented on the input side of the router.
    typedef struct packed {
        logic [BEAT_SEL_W-1:0]  sel;
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Every output channel index must be expressible on the select bus.
    function automatic bit sel_fits(input int n_out, input int sel_w);
        return (n_out <= (1 << sel_w));
    endfunction

    // All-ones value of a cnt_w-bit counter; the drop counter stops here.
    function automatic logic [31:0] cnt_sat(input int cnt_w);
        if (cnt_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage : dmux_router_pkg
`default_nettype wire

// File: rtl/dmux_router_slot.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_slot
//  Purpose  : One-entry registered output buffer with a valid/ready
//             handshake. A write in the same cycle as a drain replaces the
//             held beat without a bubble.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_wr_en       - load i_wr_data (only issued when the slot can
//                             take it: empty, or draining this cycle)
//             i_wr_data     - payload to load
//             i_rd_ready    - consumer takes the held beat this cycle
//             o_valid       - slot holds a beat
//             o_data        - held payload (stable while held and not drained)
//  Revision : 1.0  initial release
// ============================================================================
module dmux_slot
    import dmux_router_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A ready while EMPTY is simply ignored; a write always lands in FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_wr_en) begin
                    w_state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (i_rd_ready && !i_wr_en) begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            default: begin
                w_state_nxt = SLOT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_wr_en) begin
            r_data <= i_wr_data;
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

endmodule : dmux_slot
`default_nettype wire

// File: rtl/dmux_router.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_router
//  Purpose  : Steers each beat of a single valid/ready input stream to one of
//             N_OUT buffered output channels chosen by a per-beat select.
//             Beats with an out-of-range select are accepted, discarded and
//             counted on a saturating drop counter.
//  Ports    : CLK, RST   - clock, synchronous active-high reset
//             IN_VALID / IN_READY / IN_DATA / SEL - input stream
//             OUT_VALID[k] / OUT_READY[k] / OUT_DATA[k*WIDTH +: WIDTH]
//                        - output channel k
//             DROP       - pulse: a beat was discarded in the previous cycle
//             DROP_CNT   - saturating count of discarded beats
//  Revision : 1.0  initial release
// ============================================================================
module dmux_router
    import dmux_router_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [WIDTH-1:0]       IN_DATA,
    input  logic [SEL_W-1:0]       SEL,
    output logic [N_OUT-1:0]       OUT_VALID,
    input  logic [N_OUT-1:0]       OUT_READY,
    output logic [N_OUT*WIDTH-1:0] OUT_DATA,
    output logic                   DROP,
    output logic [CNT_W-1:0]       DROP_CNT
);

    localparam bit               c_sel_ok        = sel_fits(N_OUT, SEL_W);
    localparam logic [CNT_W-1:0] c_drop_cnt_max  = CNT_W'(cnt_sat(CNT_W));

    generate
        if (!c_sel_ok) begin : g_sel_check
            $error("dmux_router: N_OUT does not fit in SEL_W select bits");
        end
    endgenerate

    logic [N_OUT-1:0] w_sel_hit;
    logic [N_OUT-1:0] w_wr_en;
    logic [N_OUT-1:0] w_out_valid;
    logic             w_in_range;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_drop_now;
    logic             r_drop;
    logic [CNT_W-1:0] r_drop_cnt;

    // One-hot decode of SEL. An out-of-range select decodes to all zeros,
    // which doubles as the range test and keeps SEL from ever indexing past
    // the last channel.
    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_slot
            assign w_sel_hit[k] = (SEL == SEL_W'(k));
            assign w_wr_en[k]   = w_accept & w_sel_hit[k];

            dmux_slot #(
                .WIDTH      (WIDTH)
            ) u_slot (
                .clk        (CLK),
                .rst        (RST),
                .i_wr_en    (w_wr_en[k]),
                .i_wr_data  (IN_DATA),
                .i_rd_ready (OUT_READY[k]),
                .o_valid    (w_out_valid[k]),
                .o_data     (OUT_DATA[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign w_in_range = |w_sel_hit;

    // Only the addressed slot can stall the input; it can take a beat when
    // empty or when its current beat is leaving this same cycle.
    assign w_in_ready = w_in_range ? |(w_sel_hit & (~w_out_valid | OUT_READY))
                                   : 1'b1;
    assign w_accept   = IN_VALID & w_in_ready;
    assign w_drop_now = w_accept & ~w_in_range;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop <= w_drop_now;
            if (w_drop_now && (r_drop_cnt != c_drop_cnt_max)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = w_out_valid;
    assign DROP      = r_drop;
    assign DROP_CNT  = r_drop_cnt;

endmodule : dmux_router
`default_nettype wire
